flag_fifo_buf: RTL

Parametrised multi-entry successor to the single-word flagged buffer. It holds up to 2^DEPTH_BITS words between a producer strobe (set_flag) and a consumer acknowledge (clr_flag), such as a UART receiver and the host logic. It adds occupancy reporting, a full indication, and a sticky overrun flag. A build-time mode selects whether a write into a full buffer drops the new word or overwrites the oldest one.

---
 rtl/flag_fifo_buf_pkg.sv | 22 ++
 rtl/flag_fifo_buf_ctrl.sv | 98 +++++++++
 rtl/flag_fifo_buf.sv | 77 +++++++
 3 files changed

// File: rtl/flag_fifo_buf_pkg.sv
// -----------------------------------------------------------------------------
// flag_fifo_buf_pkg
// Shared types for the flagged FIFO buffer. Defines the encoding of the
// per-cycle strobe combination that the control logic acts on.
// -----------------------------------------------------------------------------
package flag_fifo_buf_pkg;

  // Per-cycle operation, encoded as {push, pop}. The pop bit is already
  // qualified with non-empty, so a pop on an empty buffer never reaches the
  // control logic.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/flag_fifo_buf_ctrl.sv
// -----------------------------------------------------------------------------
// flag_fifo_buf_ctrl
// Pointer, occupancy and overrun control for flag_fifo_buf.
//   clk, reset       : clock, asynchronous active-high reset
//   set_flag         : push strobe
//   clr_flag         : pop strobe (ignored while empty)
//   clr_overrun      : clears the sticky overrun flag (an overrun event wins)
//   wr_en, wr_ptr    : storage write enable and address
//   rd_ptr           : address of the head (oldest) word
//   count            : stored words, 0..2^DEPTH_BITS
//   flag, full       : non-empty / full, decoded from the registered count
//   overrun          : sticky, set by any push while full without a pop
// -----------------------------------------------------------------------------
module flag_fifo_buf_ctrl
  import flag_fifo_buf_pkg::*;
#(
  parameter int DEPTH_BITS = 2,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_flag,
  input  logic                  clr_flag,
  input  logic                  clr_overrun,
  output logic                  wr_en,
  output logic [DEPTH_BITS-1:0] wr_ptr,
  output logic [DEPTH_BITS-1:0] rd_ptr,
  output logic [DEPTH_BITS:0]   count,
  output logic                  flag,
  output logic                  full,
  output logic                  overrun
);

  localparam logic [DEPTH_BITS:0] DEPTH = (DEPTH_BITS + 1)'(1 << DEPTH_BITS);

  logic pop;
  logic ovf_evt;
  op_e  op;

  assign flag = (count != '0);
  assign full = (count == DEPTH);
  assign pop  = clr_flag && flag;
  assign op   = decode_op(set_flag, pop);

  // A push into a full buffer with no simultaneous pop is an overrun event,
  // whichever full-buffer policy is built in.
  assign ovf_evt = (op == OP_PUSH) && full;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    wr_en = 1'b0;
    case (op)
      OP_PUSH: wr_en = !full || OVERWRITE;
      OP_BOTH: wr_en = 1'b1;
      default: wr_en = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (!full) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
          end else if (OVERWRITE) begin
            // Oldest word is discarded: both pointers move, count holds.
            wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + 1'b1;
          count  <= count - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            overrun <= 1'b0;
    else if (ovf_evt)     overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: rtl/flag_fifo_buf.sv
// -----------------------------------------------------------------------------
// flag_fifo_buf
// Multi-entry flagged buffer between a producer strobe and a consumer
// acknowledge. Holds up to 2^DEPTH_BITS words of W bits.
//   clk, reset   : clock, asynchronous active-high reset
//   set_flag     : push strobe, din captured
//   clr_flag     : pop strobe, head word retired
//   clr_overrun  : clears the sticky overrun flag
//   din          : write data
//   flag         : buffer non-empty
//   dout         : head (oldest) word, 0 when empty
//   full         : count == 2^DEPTH_BITS
//   overrun      : sticky push-while-full indication
//   count        : number of stored words
// OVERWRITE=0 drops a word pushed into a full buffer; OVERWRITE=1 replaces
// the oldest word with it.
// -----------------------------------------------------------------------------
module flag_fifo_buf
  import flag_fifo_buf_pkg::*;
#(
  parameter int W          = 8,
  parameter int DEPTH_BITS = 2,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_flag,
  input  logic                clr_flag,
  input  logic                clr_overrun,
  input  logic [W-1:0]        din,
  output logic                flag,
  output logic [W-1:0]        dout,
  output logic                full,
  output logic                overrun,
  output logic [DEPTH_BITS:0] count
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic                  wr_en;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [W-1:0]          mem [DEPTH];

  flag_fifo_buf_ctrl #(
    .DEPTH_BITS (DEPTH_BITS),
    .OVERWRITE  (OVERWRITE)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .set_flag    (set_flag),
    .clr_flag    (clr_flag),
    .clr_overrun (clr_overrun),
    .wr_en       (wr_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .flag        (flag),
    .full        (full),
    .overrun     (overrun)
  );

  // NOTE: the array is reset explicitly so that every entry is 0 after reset;
  // this keeps it in flops rather than a RAM macro, which is fine at this
  // depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Combinational read of registered state only; no input reaches dout.
  assign dout = flag ? mem[rd_ptr] : '0;

endmodule
